// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute/writeback sequencer that drives an 8-bit ALU
// Ports: clk, rst_n (async active-low); imem_req/imem_addr/imem_ack/imem_rdata form the fetch handshake;
// alu_opcode/alu_operand1/alu_operand2 go to the ALU and alu_result comes back; halted is a sticky halt flag;
// pc is the program counter; dbg_reg_sel/dbg_reg_data give a combinational register-file read.
module cpu_control_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int PC_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_ack,
  input  logic [15:0]           imem_rdata,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_operand1,
  output logic [DATA_WIDTH-1:0] alu_operand2,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  halted,
  output logic [PC_WIDTH-1:0]   pc,
  input  logic [1:0]            dbg_reg_sel,
  output logic [DATA_WIDTH-1:0] dbg_reg_data
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, WRITEBACK = 3'd3, HALT = 3'd4;
  localparam logic [2:0] OP_JMP = 3'b101, OP_NOP = 3'b110, OP_HALT = 3'b111;
  logic [2:0] state_q, state_d, opc_q, opc_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0][DATA_WIDTH-1:0] rf_q, rf_d;
  logic [DATA_WIDTH-1:0] result_q, result_d, op1_q, op1_d, op2_q, op2_d;
  logic halted_q, halted_d;
  logic [2:0] op;
  logic imm;
  logic [1:0] rd, rs;
  assign op = ir_q[15:13];
  assign imm = ir_q[12];
  assign rd = ir_q[11:10];
  assign rs = ir_q[9:8];
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    rf_d = rf_q;
    result_d = result_q;
    opc_d = opc_q;
    op1_d = op1_q;
    op2_d = op2_q;
    halted_d = halted_q;
    case (state_q)
      FETCH: if (imem_ack) begin
        ir_d = imem_rdata;
        pc_d = pc_q + PC_WIDTH'(1);
        state_d = DECODE;
      end
      DECODE: begin
        opc_d = op;
        op1_d = rf_q[rd];
        op2_d = imm ? DATA_WIDTH'(ir_q[7:0]) : rf_q[rs];
        pc_d = op == OP_JMP ? PC_WIDTH'(ir_q[7:0]) : pc_q;
        halted_d = op == OP_HALT;
        state_d = op == OP_HALT ? HALT : (op == OP_JMP || op == OP_NOP) ? FETCH : EXECUTE;
      end
      EXECUTE: begin
        result_d = alu_result;
        state_d = WRITEBACK;
      end
      WRITEBACK: begin
        rf_d[rd] = result_q;
        state_d = FETCH;
      end
      HALT: ;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
      rf_q <= '0;
      result_q <= '0;
      opc_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      rf_q <= rf_d;
      result_q <= result_d;
      opc_q <= opc_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      halted_q <= halted_d;
    end
  end
  // Gated by rst_n so the request drops the moment reset is asserted, not at the next edge.
  assign imem_req = rst_n && state_q == FETCH;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign alu_opcode = opc_q;
  assign alu_operand1 = op1_q;
  assign alu_operand2 = op2_q;
  assign halted = halted_q;
  assign dbg_reg_data = rf_q[dbg_reg_sel];
endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: directed self-checking bench for cpu_control_unit with a behavioural ALU
module tb_cpu_control_unit;
  logic clk = 1'b0, rst_n = 1'b0, imem_req, imem_ack = 1'b0, halted;
  logic [7:0] imem_addr, alu_operand1, alu_operand2, alu_result, pc, dbg_reg_data;
  logic [15:0] imem_rdata = 16'h0;
  logic [2:0] alu_opcode;
  logic [1:0] dbg_reg_sel = 2'd0;
  int tests = 0, failed = 0;
  always #5 clk = ~clk;
  cpu_control_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .alu_opcode(alu_opcode), .alu_operand1(alu_operand1),
    .alu_operand2(alu_operand2), .alu_result(alu_result), .halted(halted), .pc(pc),
    .dbg_reg_sel(dbg_reg_sel), .dbg_reg_data(dbg_reg_data)
  );
  always_comb
    case (alu_opcode)
      3'd0: alu_result = alu_operand1 + alu_operand2;
      3'd1: alu_result = alu_operand1 - alu_operand2;
      3'd2: alu_result = alu_operand1 & alu_operand2;
      3'd3: alu_result = alu_operand1 | alu_operand2;
      3'd4: alu_result = alu_operand2;
      default: alu_result = 8'h00;
    endcase
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [15:0] instr);
    imem_ack = 1'b1;
    imem_rdata = instr;
    step();
    imem_ack = 1'b0;
  endtask
  task automatic read_reg(input logic [1:0] sel, output logic [7:0] val);
    dbg_reg_sel = sel;
    #1;
    val = dbg_reg_data;
  endtask
  task automatic test_reset();
    logic [7:0] v;
    rst_n = 1'b0;
    step();
    step();
    tests++; if ({imem_req, halted, pc} !== {1'b0, 1'b0, 8'h00}) begin failed++; $display("FAIL reset_outs got req=%b halt=%b pc=%h exp 0 0 00", imem_req, halted, pc); end
    tests++; if ({alu_opcode, alu_operand1, alu_operand2} !== 19'h0) begin failed++; $display("FAIL reset_alu got %h %h %h exp 0 00 00", alu_opcode, alu_operand1, alu_operand2); end
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), v);
      tests++; if (v !== 8'h00) begin failed++; $display("FAIL reset_R%0d got %h exp 00", r, v); end
    end
    rst_n = 1'b1;
    #1;
    tests++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin failed++; $display("FAIL reset_release got req=%b addr=%h exp 1 00", imem_req, imem_addr); end
  endtask
  task automatic test_mov_imm();
    logic [7:0] v;
    issue(16'h9405);
    step();
    tests++; if ({alu_opcode, alu_operand2} !== {3'd4, 8'h05}) begin failed++; $display("FAIL mov_exec got op=%h opnd2=%h exp 4 05", alu_opcode, alu_operand2); end
    step();
    step();
    read_reg(2'd1, v);
    tests++; if (v !== 8'h05) begin failed++; $display("FAIL mov_R1 got %h exp 05", v); end
    tests++; if ({pc, imem_req} !== {8'h01, 1'b1}) begin failed++; $display("FAIL mov_pc got pc=%h req=%b exp 01 1", pc, imem_req); end
  endtask
  task automatic test_arith();
    logic [7:0] v;
    issue(16'h14FF);
    repeat (3) step();
    read_reg(2'd1, v);
    tests++; if (v !== 8'h04) begin failed++; $display("FAIL add_wrap got %h exp 04", v); end
    issue(16'h9803);
    repeat (3) step();
    read_reg(2'd2, v);
    tests++; if (v !== 8'h03) begin failed++; $display("FAIL mov_R2 got %h exp 03", v); end
    issue(16'h2600);
    step();
    tests++; if ({alu_opcode, alu_operand1, alu_operand2} !== {3'd1, 8'h04, 8'h03}) begin failed++; $display("FAIL sub_opnds got %h %h %h exp 1 04 03", alu_opcode, alu_operand1, alu_operand2); end
    step();
    step();
    read_reg(2'd1, v);
    tests++; if (v !== 8'h01) begin failed++; $display("FAIL sub_R1 got %h exp 01", v); end
  endtask
  task automatic test_fetch_wait();
    logic [7:0] v;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if ({imem_req, imem_addr, pc} !== {1'b1, 8'h04, 8'h04}) begin failed++; $display("FAIL wait_%0d got req=%b addr=%h pc=%h exp 1 04 04", i, imem_req, imem_addr, pc); end
    end
    issue(16'h9C5A);
    tests++; if ({imem_req, pc} !== {1'b0, 8'h05}) begin failed++; $display("FAIL wait_ack got req=%b pc=%h exp 0 05", imem_req, pc); end
    imem_ack = 1'b1;
    imem_rdata = 16'hE000;
    step();
    imem_ack = 1'b0;
    tests++; if ({alu_opcode, alu_operand2, pc, halted} !== {3'd4, 8'h5A, 8'h05, 1'b0}) begin failed++; $display("FAIL decode_ack got op=%h opnd2=%h pc=%h halt=%b exp 4 5a 05 0", alu_opcode, alu_operand2, pc, halted); end
    step();
    step();
    read_reg(2'd3, v);
    tests++; if (v !== 8'h5A) begin failed++; $display("FAIL wait_R3 got %h exp 5a", v); end
  endtask
  task automatic test_jump();
    issue(16'hA010);
    step();
    tests++; if ({imem_req, imem_addr} !== {1'b1, 8'h10}) begin failed++; $display("FAIL jmp got req=%b addr=%h exp 1 10", imem_req, imem_addr); end
    issue(16'hA0FF);
    step();
    tests++; if (imem_addr !== 8'hFF) begin failed++; $display("FAIL jmp_ff got %h exp ff", imem_addr); end
    issue(16'hC000);
    tests++; if (pc !== 8'h00) begin failed++; $display("FAIL pc_wrap got %h exp 00", pc); end
    step();
    tests++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin failed++; $display("FAIL nop got req=%b addr=%h exp 1 00", imem_req, imem_addr); end
  endtask
  task automatic test_halt();
    logic [7:0] v;
    issue(16'hE000);
    step();
    tests++; if ({halted, imem_req} !== 2'b10) begin failed++; $display("FAIL halt_enter got halt=%b req=%b exp 1 0", halted, imem_req); end
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      imem_rdata = 16'h9405;
      step();
      tests++; if ({halted, imem_req, pc} !== {1'b1, 1'b0, 8'h01}) begin failed++; $display("FAIL halt_hold_%0d got halt=%b req=%b pc=%h exp 1 0 01", i, halted, imem_req, pc); end
    end
    imem_ack = 1'b0;
    read_reg(2'd1, v);
    tests++; if (v !== 8'h01) begin failed++; $display("FAIL halt_R1 got %h exp 01", v); end
    read_reg(2'd2, v);
    tests++; if (v !== 8'h03) begin failed++; $display("FAIL halt_R2 got %h exp 03", v); end
  endtask
  task automatic test_reset_mid_fetch();
    logic [7:0] v;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    issue(16'h9401);
    repeat (3) step();
    read_reg(2'd1, v);
    tests++; if ({v, pc} !== {8'h01, 8'h01}) begin failed++; $display("FAIL pre_rst got R1=%h pc=%h exp 01 01", v, pc); end
    imem_ack = 1'b1;
    imem_rdata = 16'h9477;
    #1;
    rst_n = 1'b0;
    #1;
    tests++; if ({imem_req, halted, pc} !== {1'b0, 1'b0, 8'h00}) begin failed++; $display("FAIL rst_mid got req=%b halt=%b pc=%h exp 0 0 00", imem_req, halted, pc); end
    for (int r = 0; r < 4; r++) begin
      read_reg(2'(r), v);
      tests++; if (v !== 8'h00) begin failed++; $display("FAIL rst_mid_R%0d got %h exp 00", r, v); end
    end
    step();
    imem_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    tests++; if ({imem_req, imem_addr} !== {1'b1, 8'h00}) begin failed++; $display("FAIL rst_restart got req=%b addr=%h exp 1 00", imem_req, imem_addr); end
    repeat (2) step();
    read_reg(2'd1, v);
    tests++; if ({v, pc, imem_req} !== {8'h00, 8'h00, 1'b1}) begin failed++; $display("FAIL rst_no_partial got R1=%h pc=%h req=%b exp 00 00 1", v, pc, imem_req); end
  endtask
  initial begin
    test_reset();
    test_mov_imm();
    test_arith();
    test_fetch_wait();
    test_jump();
    test_halt();
    test_reset_mid_fetch();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
